// File: rtl/ahb_input_hold_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_input_hold_stage
//  Purpose  : Per-master AHB input stage for the bus matrix.
//             - Accepts address phases from one master.
//             - Holds any transfer the shared output port cannot take at once.
//             - Raises the request to the output arbiter.
//             - Tracks its own data phase, so it can return the slave's
//               HREADY/HRESP to the master or stall the master while a
//               transfer is held.
//  Config   : AHB_INPUT_BYPASS_EN
//             - Defined: a granted transfer passes straight through with no
//               added latency.
//             - Undefined: every accepted transfer is registered first.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_input_hold_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    // Master side
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    // Arbiter / output port side
    output logic                  req_port,
    input  logic                  active_in,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI
);

    localparam logic [1:0] c_TRANS_IDLE = 2'b00;

    // Hold register and stage flags
    logic                  r_pend;
    logic                  r_dphase;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [3:0]            r_hprot;
    logic                  r_hmastlock;

    logic w_accept;
    logic w_issue;
    logic w_capture;

    // Only NONSEQ/SEQ qualify; IDLE and BUSY never start a transfer here.
    assign w_accept = HSELS & HREADYS & HTRANSS[1];

`ifdef AHB_INPUT_BYPASS_EN
    // A live accept can go out directly when granted.
    // Capture it only when it cannot.
    assign w_issue   = active_in & HREADYM & (r_pend | w_accept);
    assign w_capture = w_accept & ~w_issue;
`else
    // Every accepted transfer goes through the hold register first.
    assign w_issue   = active_in & HREADYM & r_pend;
    assign w_capture = w_accept;
`endif

    // Hold register capture, pending flag and data-phase tracking
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend      <= 1'b0;
            r_dphase    <= 1'b0;
            r_haddr     <= '0;
            r_htrans    <= c_TRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hburst    <= '0;
            r_hprot     <= '0;
            r_hmastlock <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend      <= 1'b1;
                r_haddr     <= HADDRS;
                r_htrans    <= HTRANSS;
                r_hwrite    <= HWRITES;
                r_hsize     <= HSIZES;
                r_hburst    <= HBURSTS;
                r_hprot     <= HPROTS;
                r_hmastlock <= HMASTLOCKS;
            end else if (w_issue) begin
                r_pend      <= 1'b0;
            end
            // A data phase starts only when the output port's previous
            // data phase ends.
            if (HREADYM) begin
                r_dphase <= w_issue;
            end
        end
    end

    // Address phase presented to the output stage
    always_comb begin
        HADDRI     = r_haddr;
        HTRANSI    = r_pend ? r_htrans : c_TRANS_IDLE;
        HWRITEI    = r_hwrite;
        HSIZEI     = r_hsize;
        HBURSTI    = r_hburst;
        HPROTI     = r_hprot;
        HMASTLOCKI = r_hmastlock;
        req_port   = r_pend;
`ifdef AHB_INPUT_BYPASS_EN
        if (!r_pend) begin
            HADDRI     = HADDRS;
            HTRANSI    = w_accept ? HTRANSS : c_TRANS_IDLE;
            HWRITEI    = HWRITES;
            HSIZEI     = HSIZES;
            HBURSTI    = HBURSTS;
            HPROTI     = HPROTS;
            HMASTLOCKI = HMASTLOCKS;
        end
        req_port = r_pend | w_accept;
`endif
    end

    // Master-side response: stall while held, otherwise mirror the slave
    // during our own data phase.
    always_comb begin
        HREADYOUTS = 1'b1;
        if (r_pend) begin
            HREADYOUTS = 1'b0;
        end else if (r_dphase) begin
            HREADYOUTS = HREADYM;
        end
        HRESPS = r_dphase ? HRESPM : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_input_hold_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_input_hold_stage
//  Purpose  : Self-checking bench for ahb_input_hold_stage.
//             - Directed scenarios first, then randomized traffic.
//             - DUT outputs are compared against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_input_hold_stage;

    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELS = 1'b0;
    logic [31:0] HADDRS = '0;
    logic [1:0]  HTRANSS = '0;
    logic        HWRITES = 1'b0;
    logic [2:0]  HSIZES = '0;
    logic [2:0]  HBURSTS = '0;
    logic [3:0]  HPROTS = '0;
    logic        HMASTLOCKS = 1'b0;
    logic        HREADYS = 1'b1;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        req_port;
    logic        active_in = 1'b0;
    logic        HREADYM = 1'b1;
    logic        HRESPM = 1'b0;
    logic [31:0] HADDRI;
    logic [1:0]  HTRANSI;
    logic        HWRITEI;
    logic [2:0]  HSIZEI;
    logic [2:0]  HBURSTI;
    logic [3:0]  HPROTI;
    logic        HMASTLOCKI;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    // - held : transfers waiting for the output port (0 or 1 entry).
    // - in_dp: one of our transfers currently occupies the data phase.
    // - last : most recently captured transfer.
    xfer_t held[$];
    bit    in_dp = 1'b0;
    xfer_t last  = '0;

    ahb_input_hold_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .req_port(req_port), .active_in(active_in), .HREADYM(HREADYM), .HRESPM(HRESPM),
        .HADDRI(HADDRI), .HTRANSI(HTRANSI), .HWRITEI(HWRITEI), .HSIZEI(HSIZEI),
        .HBURSTI(HBURSTI), .HPROTI(HPROTI), .HMASTLOCKI(HMASTLOCKI)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle:
    // - drive inputs at negedge;
    // - check outputs 1 time unit later;
    // - advance the model after posedge.
    task automatic step(input logic rst, input logic sel, input logic [1:0] tr,
                        input logic [31:0] ad, input logic act, input logic rdym,
                        input logic rsp);
        xfer_t live, src;
        logic  pend, rdy, accept, issue, exp_req;
        logic [1:0] exp_trans;
        @(negedge HCLK);
        HRESET = rst; HSELS = sel; HTRANSS = tr; HADDRS = ad;
        HWRITES = 1'($urandom); HSIZES = 3'($urandom); HBURSTS = 3'($urandom);
        HPROTS = 4'($urandom); HMASTLOCKS = 1'($urandom);
        active_in = act; HREADYM = rdym; HRESPM = rsp;
        live = '{addr: ad, trans: tr, write: HWRITES, size: HSIZES, burst: HBURSTS,
                 prot: HPROTS, lock: HMASTLOCKS};
        pend = (held.size() != 0);
        // The master sees the ready returned by this stage.
        rdy = pend ? 1'b0 : (in_dp ? rdym : 1'b1);
        HREADYS = rdy;
        accept = sel & rdy & tr[1];
`ifdef AHB_INPUT_BYPASS_EN
        issue     = act & rdym & (pend | accept);
        src       = pend ? held[0] : live;
        exp_trans = pend ? held[0].trans : (accept ? tr : 2'b00);
        exp_req   = pend | accept;
`else
        issue     = act & rdym & pend;
        src       = pend ? held[0] : last;
        exp_trans = pend ? held[0].trans : 2'b00;
        exp_req   = pend;
`endif
        #1;
        check_value("hreadyout", 64'(HREADYOUTS), 64'(rdy));
        check_value("hresp", 64'(HRESPS), 64'(in_dp ? rsp : 1'b0));
        check_value("req_port", 64'(req_port), 64'(exp_req));
        check_value("htrans", 64'(HTRANSI), 64'(exp_trans));
        check_value("haddr", 64'(HADDRI), 64'(src.addr));
        check_value("ctrl", 64'({HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI}),
                    64'({src.write, src.size, src.burst, src.prot, src.lock}));
        @(posedge HCLK);
        if (rst) begin
            held.delete();
            in_dp = 1'b0;
            last  = '0;
        end else begin
            if (rdym) in_dp = issue;
`ifdef AHB_INPUT_BYPASS_EN
            if (accept && !issue) begin
                held.push_back(live);
                last = live;
            end else if (issue && pend) begin
                void'(held.pop_front());
            end
`else
            if (accept) begin
                held.push_back(live);
                last = live;
            end else if (issue) begin
                void'(held.pop_front());
            end
`endif
        end
    endtask

    initial begin
        // Reset for two cycles
        step(1, 0, 2'b00, 32'h0, 0, 1, 0);
        step(1, 0, 2'b00, 32'h0, 0, 1, 0);
        // Granted single transfer, then its data phase with one wait state
        step(0, 1, 2'b10, 32'h1000, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 0, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        // Held transfer: three ungranted cycles, then grant
        step(0, 1, 2'b10, 32'h2000, 0, 1, 0);
        step(0, 1, 2'b10, 32'h2000, 0, 1, 0);
        step(0, 1, 2'b10, 32'h2000, 0, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        // Slave wait: two cycles in the data phase
        step(0, 1, 2'b10, 32'h2400, 1, 1, 0);
        step(0, 1, 2'b10, 32'h2400, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 0, 0);
        step(0, 0, 2'b00, 32'h0, 1, 0, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        // Two-cycle ERROR response
        step(0, 1, 2'b10, 32'h2800, 1, 1, 0);
        step(0, 1, 2'b10, 32'h2800, 1, 1, 0);
        step(0, 0, 2'b00, 32'h0, 1, 0, 1);
        step(0, 0, 2'b00, 32'h0, 1, 1, 1);
        step(0, 0, 2'b00, 32'h0, 1, 1, 0);
        // Reset while a transfer is held
        step(0, 1, 2'b11, 32'h3000, 0, 1, 0);
        step(1, 1, 2'b11, 32'h3000, 0, 1, 0);
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 2'($urandom),
                 $urandom,
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 20));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
